// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that shares the SPI RAM command port between two requesters.
// A granted request becomes the RAM's two-word command sequence; read data comes back on ackN.
module ram_cmd_arbiter #(
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 1,
  parameter int RD_TMO   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       err0,
  output logic       err1,
  output logic       busy,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_HG > RD_TMO) ? MAX_HG : RD_TMO;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(RD_TMO - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RD, RESP, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sel;
  logic          we_q;
  logic          rr;
  logic [7:0]    wdata_q;

  logic          gnt;
  logic          g_we;
  logic [7:0]    g_addr;
  logic [7:0]    g_wdata;
  logic          resp_go;
  logic [7:0]    resp_data;
  logic          resp_err;

  // rr holds the last granted port, so a tie goes to the other one.
  always_comb begin
    gnt       = (req0 && req1) ? ~rr : req1;
    g_we      = gnt ? we1 : we0;
    g_addr    = gnt ? addr1 : addr0;
    g_wdata   = gnt ? wdata1 : wdata0;
    resp_go   = 1'b0;
    if (state == DATA && cnt == HOLD_LAST && we_q)
      resp_go = 1'b1;
    if (state == WAIT_RD && (ram_tx_valid || cnt == TMO_LAST))
      resp_go = 1'b1;
    resp_data = ram_tx_valid ? ram_dout : 8'h00;
    resp_err  = ~ram_tx_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sel          <= 1'b0;
      we_q         <= 1'b0;
      rr           <= 1'b1;
      wdata_q      <= 8'h00;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= 8'h00;
      rdata1       <= 8'h00;
      err0         <= 1'b0;
      err1         <= 1'b0;
      busy         <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state        <= ADDR;
            cnt          <= '0;
            sel          <= gnt;
            rr           <= gnt;
            we_q         <= g_we;
            wdata_q      <= g_wdata;
            busy         <= 1'b1;
            ram_rx_valid <= 1'b1;
            ram_din      <= {(g_we ? 2'b00 : 2'b10), g_addr};
          end
        end
        ADDR: begin
          if (cnt == HOLD_LAST) begin
            state   <= DATA;
            cnt     <= '0;
            ram_din <= we_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == HOLD_LAST) begin
            state        <= we_q ? RESP : WAIT_RD;
            cnt          <= '0;
            ram_rx_valid <= 1'b0;
            ram_din      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_RD: begin
          if (resp_go)
            state <= RESP;
          else
            cnt <= cnt + CW'(1);
        end
        RESP: begin
          state <= GAP;
          cnt   <= '0;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          ram_rx_valid <= 1'b0;
          ram_din      <= '0;
        end
      endcase

      // Writes complete without touching rdata; reads report captured data or a timeout.
      if (resp_go) begin
        if (sel) begin
          ack1 <= 1'b1;
          if (we_q) begin
            err1 <= 1'b0;
          end else begin
            rdata1 <= resp_data;
            err1   <= resp_err;
          end
        end else begin
          ack0 <= 1'b1;
          if (we_q) begin
            err0 <= 1'b0;
          end else begin
            rdata0 <= resp_data;
            err0   <= resp_err;
          end
        end
      end
    end
  end

endmodule
